// File: rtl/cache_request_controller_if.sv
// Bundles the trace-command, data-structure-access and statistics signals of
// the cache request controller; slave is the controller side, master the environment.
interface cache_request_controller_if #(
  parameter int tagBits   = 12,
  parameter int indexBits = 14
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd;
  logic [31:0]          address;
  logic [indexBits-1:0] index;
  logic [tagBits-1:0]   addressTag;
  logic                 read;
  logic                 access_valid;
  logic                 access_done;
  logic                 access_hit;
  logic [31:0]          read_count;
  logic [31:0]          write_count;
  logic [31:0]          hit_count;
  logic [31:0]          miss_count;
  logic                 stats_valid;

  modport slave (
    input  cmd_valid, cmd, address, access_done, access_hit,
    output cmd_ready, index, addressTag, read, access_valid,
           read_count, write_count, hit_count, miss_count, stats_valid
  );

  modport master (
    output cmd_valid, cmd, address, access_done, access_hit,
    input  cmd_ready, index, addressTag, read, access_valid,
           read_count, write_count, hit_count, miss_count, stats_valid
  );
endinterface

// File: rtl/cache_request_controller.sv
// Accepts trace commands, issues one cache access per read/write/fetch and keeps
// saturating read/write/hit/miss statistics that can be cleared or reported.
module cache_request_controller #(
  parameter int indexBits  = 14,
  parameter int tagBits    = 12,
  parameter int offsetBits = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  cache_request_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    CLEAR  = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   accept_s;
  logic   unused_offset_s;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

  assign unused_offset_s = ^bus.address[offsetBits-1:0];
  assign bus.cmd_ready   = (state_r == IDLE) && !reset;

  // Next-state decode; opcodes outside the table are accepted and dropped.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept_s = 1'b1;
          case (bus.cmd)
            4'd0, 4'd1, 4'd2: next_state_s = ISSUE;
            4'd8:             next_state_s = CLEAR;
            4'd9:             next_state_s = REPORT;
            default:          next_state_s = IDLE;
          endcase
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: next_state_s = WAIT;
      WAIT: begin
        if (bus.access_done) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT;
        end
      end
      CLEAR:   next_state_s = IDLE;
      REPORT:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register plus registered access request and strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      bus.index        <= {indexBits{1'b0}};
      bus.addressTag   <= {tagBits{1'b0}};
      bus.read         <= 1'b0;
      bus.access_valid <= 1'b0;
      bus.stats_valid  <= 1'b0;
    end else begin
      state_r          <= next_state_s;
      bus.access_valid <= (next_state_s == ISSUE);
      bus.stats_valid  <= (next_state_s == REPORT);
      // Request fields only move on a new access so they stay stable through WAIT.
      if (accept_s && (next_state_s == ISSUE)) begin
        bus.index      <= bus.address[offsetBits+indexBits-1:offsetBits];
        bus.addressTag <= bus.address[31:32-tagBits];
        bus.read       <= (bus.cmd != 4'd1);
      end
    end
  end

  // Statistics counters: updated on access completion, zeroed by CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.read_count  <= 32'd0;
      bus.write_count <= 32'd0;
      bus.hit_count   <= 32'd0;
      bus.miss_count  <= 32'd0;
    end else begin
      case (state_r)
        WAIT: begin
          if (bus.access_done) begin
            if (bus.read) begin
              bus.read_count <= sat_inc(bus.read_count);
            end else begin
              bus.write_count <= sat_inc(bus.write_count);
            end
            if (bus.access_hit) begin
              bus.hit_count <= sat_inc(bus.hit_count);
            end else begin
              bus.miss_count <= sat_inc(bus.miss_count);
            end
          end
        end
        CLEAR: begin
          bus.read_count  <= 32'd0;
          bus.write_count <= 32'd0;
          bus.hit_count   <= 32'd0;
          bus.miss_count  <= 32'd0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
